// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch-flush / multiply-divide stall control
// for the ID/EX bubble, PC and IF/ID enables, plus a saturating stall counter.
module hazard_stall_ctrl #(
   parameter int REG_W     = 4,
   parameter int MD_CYCLES = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_md,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memread,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             hazard,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t           state_q, state_d;
   logic [3:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             lu;

   // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
   assign lu = ex_memread && (ex_rd != '0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      hazard     = 1'b0;
      md_busy    = 1'b0;
      state_d    = state_q;
      md_cnt_d   = md_cnt_q;
      if (state_q == MD_BUSY) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         hazard     = 1'b1;
         md_busy    = 1'b1;
         md_cnt_d   = md_cnt_q - 4'd1;
         if (md_cnt_q == 4'd1) begin
            state_d  = IDLE;
            md_cnt_d = 4'd0;
         end
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         hazard     = 1'b1;
      end else if (lu) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         hazard     = 1'b1;
      end else if (id_md) begin
         state_d  = MD_BUSY;
         md_cnt_d = 4'(MD_CYCLES - 1);
      end
   end

   assign stall_d      = (!pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
   assign stall_cycles = stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         md_cnt_q <= 4'd0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         stall_q  <= stall_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed plus random stimulus against a behavioural
// model built from remaining-busy-cycle and stall-count integers.
module tb_hazard_stall_ctrl;

   localparam int MD_CYCLES = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_md = 1'b0;
   logic       ex_memread = 1'b0, branch_taken = 1'b0;
   logic       pc_write, ifid_write, ifid_flush, hazard, md_busy;
   logic [7:0] stall_cycles;
   logic       s_pc, s_ifid, s_flush, s_haz, s_busy;
   logic [1:0] s_stall;

   int n_tests = 0;
   int n_fail  = 0;
   int md_rem  = 0;
   int n_stall = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_W(4), .MD_CYCLES(MD_CYCLES), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_md(id_md),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .hazard(hazard), .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   hazard_stall_ctrl #(.REG_W(4), .MD_CYCLES(MD_CYCLES), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_md(id_md),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
      .pc_write(s_pc), .ifid_write(s_ifid), .ifid_flush(s_flush),
      .hazard(s_haz), .md_busy(s_busy), .stall_cycles(s_stall)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input logic e_pc, input logic e_flush, input logic e_haz,
                          input logic e_busy);
      chk("pc_write", 32'(pc_write), 32'(e_pc));
      chk("ifid_write", 32'(ifid_write), 32'(e_pc));
      chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
      chk("hazard", 32'(hazard), 32'(e_haz));
      chk("md_busy", 32'(md_busy), 32'(e_busy));
      chk("stall8", 32'(stall_cycles), 32'(n_stall > 255 ? 255 : n_stall));
      chk("stall2", 32'(s_stall), 32'(n_stall > 3 ? 3 : n_stall));
      chk("sat_pc_write", 32'(s_pc), 32'(e_pc));
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, then advance the model.
   task automatic step(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                       input logic u1, input logic u2, input logic md,
                       input logic mr, input logic br);
      logic lu, busy, e_pc;
      @(negedge clk);
      id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_rs1_used = u1; id_rs2_used = u2;
      id_md = md; ex_memread = mr; branch_taken = br;
      #1;
      lu   = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      busy = md_rem > 0;
      e_pc = !(busy || (!br && lu));
      chk_all(e_pc, !busy && br, busy || br || lu, busy);
      if (busy) md_rem--;
      else if (!br && !lu && md) md_rem = MD_CYCLES - 1;
      if (!e_pc) n_stall++;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset held for two cycles, outputs must already be at their idle values
      repeat (2) @(negedge clk);
      #1 chk_all(1, 0, 0, 0);
      reset = 1'b1;
      repeat (5) idle();

      // single load-use bubble via rs2, then the same with ex_rd=0
      step(0, 3, 3, 0, 1, 0, 1, 0);
      idle();
      step(0, 0, 0, 1, 1, 0, 1, 0);
      idle();

      // branch wins over a matching load-use
      step(3, 0, 3, 1, 0, 0, 1, 1);
      idle();

      // md issue, branch pulse during busy, then back-to-back md
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      idle();
      step(0, 0, 0, 0, 0, 1, 0, 0);
      repeat (4) idle();

      // async reset asserted mid-cycle on the second busy cycle
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      md_rem = 0;
      n_stall = 0;
      chk_all(1, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // five load-use stalls: 2-bit counter must saturate at 3
      repeat (5) begin
         step(5, 0, 5, 1, 0, 0, 1, 0);
         idle();
      end

      // random traffic with a small register space to provoke matches
      for (int i = 0; i < 600; i++)
         step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
              1'($urandom), $urandom_range(0, 7) == 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard and stall controller for the 16-bit, 16-register pipeline.
- Produces the `hazard` bubble input consumed by the ID/EX pipeline buffer. It also drives PC and IF/ID write-enable and flush.
- Compares ID-stage source registers against the EX-stage destination to catch load-use hazards. Flushes on taken branches resolved in EX.
- Holds the front end for a fixed multi-cycle window while a multiply/divide occupies EX.

Parameters:
- REG_W, 4, register-number width.
- MD_CYCLES, 4, total EX occupancy of a multiply/divide in cycles. Legal range 2..15.
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  ID-stage source register 1.
- id_rs2  in  REG_W  ID-stage source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_md  in  1  ID instruction is a multiply/divide.
- ex_rd  in  REG_W  EX-stage destination register.
- ex_memread  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID buffer may load.
- ifid_flush  out  1  clear IF/ID to NOP.
- hazard  out  1  ID/EX buffer loads a bubble instead of ID contents.
- md_busy  out  1  FSM is in MD_BUSY.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- State: 2-state FSM (IDLE, MD_BUSY) plus a 4-bit down-counter md_cnt, both registered.
- Outputs are combinational from state and inputs.
- stall_cycles is registered.
- Reset (reset=0, async):
  - state=IDLE, md_cnt=0, stall_cycles=0.
  - Outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, hazard=0, md_busy=0.
- Load-use detect (lu): ex_memread=1, ex_rd!=0, and either (id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd). Register 0 never causes a hazard.
- IDLE priority, highest first:
  1. branch_taken=1: ifid_flush=1, hazard=1, pc_write=1, ifid_write=1. Stay in IDLE. lu and id_md are ignored this cycle because the ID instruction is being squashed.
  2. lu=1: pc_write=0, ifid_write=0, hazard=1, ifid_flush=0. Stay in IDLE. This is a single-cycle bubble; the next cycle re-evaluates with the load now in MEM.
  3. id_md=1: all enables 1, hazard=0 (the md instruction proceeds into EX). Next state MD_BUSY, md_cnt=MD_CYCLES-1.
  4. Otherwise: all enables 1, flush=0, hazard=0.
- MD_BUSY:
  - Outputs: pc_write=0, ifid_write=0, hazard=1, ifid_flush=0, md_busy=1.
  - Each cycle md_cnt decrements. When md_cnt==1 the next state is IDLE and md_cnt=0.
  - Total front-end hold is MD_CYCLES-1 cycles after the issue cycle.
  - branch_taken, lu and id_md are ignored in MD_BUSY; EX holds the md instruction, so a branch cannot resolve.
- Back-to-back md: on the first IDLE cycle after MD_BUSY, id_md=1 re-enters MD_BUSY normally.
- stall_cycles: increments on each rising edge where pc_write=0. It holds at 2^CNT_W-1 and never wraps.
- Reset mid-operation: asserting reset during MD_BUSY forces IDLE asynchronously. Enables return to 1 immediately, without waiting for the clock.
- No X on outputs when inputs are known. Outputs are stable for the whole cycle given stable inputs.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release, all inputs 0 -> pc_write=1, ifid_write=1, hazard=0, ifid_flush=0, stall_cycles=0 for 5 cycles.
2. Load-use: ex_memread=1, ex_rd=4'b0011, id_rs2=4'b0011, id_rs2_used=1 for one cycle, then ex_memread=0 -> exactly one cycle of hazard=1, pc_write=0, ifid_write=0; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
3. Branch over load-use: branch_taken=1 in the same cycle as a matching load-use -> ifid_flush=1, hazard=1, pc_write=1; stall_cycles unchanged.
4. Multiply/divide with MD_CYCLES=4: id_md=1 for one cycle in IDLE -> the following 3 cycles show md_busy=1, hazard=1, pc_write=0, then IDLE; stall_cycles=3. Pulse branch_taken during MD_BUSY -> no flush.
5. Async reset mid-MD: assert reset=0 between clock edges on the second MD_BUSY cycle -> md_busy=0, pc_write=1 without a clock edge; stall_cycles=0.
6. Saturation with CNT_W=2: force 5 load-use stalls -> stall_cycles reads 1, 2, 3, 3, 3.
